// File: rtl/cache_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ requesters onto one cache CPU port, one transaction in flight.
// Latency: grant in the request cycle, cache_valid_o next cycle, response pulse one cycle after cache_resp_valid_i.
// Backpressure: cache_ready_i low holds ISSUE with stable command; requesters see no ready until the arbiter is idle.
module cache_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ-1:0]            req_we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_adr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]            resp_valid_o,
  output logic [NUM_REQ-1:0]            resp_err_o,
  output logic [DATA_WIDTH-1:0]         resp_rdata_o,
  output logic                          cache_valid_o,
  input  logic                          cache_ready_i,
  output logic                          cache_we_o,
  output logic [ADDR_WIDTH-1:0]         cache_adr_o,
  output logic [DATA_WIDTH-1:0]         cache_wdata_o,
  input  logic [DATA_WIDTH-1:0]         cache_rdata_i,
  input  logic                          cache_resp_valid_i,
  output logic                          busy_o
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SUM_W = IDX_W + 1;
  // Counter only needs to reach TIMEOUT_CYCLES-1: the cycle it holds that value is the last allowed one.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   prio_ptr;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   nxt_ptr;
  logic [SUM_W-1:0]   cand;
  logic [CNT_W-1:0]   tmo_cnt;
  logic [NUM_REQ-1:0] gnt_oh;
  logic               win_found;
  logic               grant;
  logic               tmo_hit;

  // Round-robin search: first valid requester at or after prio_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      cand = {1'b0, prio_ptr} + SUM_W'(i);
      if (cand >= SUM_W'(NUM_REQ)) begin
        cand = cand - SUM_W'(NUM_REQ);
      end
      if (!win_found && req_valid_i[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // A capture never happens while reset is asserted, so ready is suppressed too.
  assign grant       = (state == IDLE) && win_found && !rst_i;
  assign req_ready_o = grant ? (NUM_REQ'(1) << win_idx) : '0;

  assign gnt_oh  = NUM_REQ'(1) << gnt_idx;
  assign nxt_ptr = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  assign cache_valid_o = (state == ISSUE);
  assign busy_o        = (state != IDLE);

  // Transaction FSM: capture, issue to cache, wait for response or timeout; response regs pulse one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      prio_ptr      <= '0;
      gnt_idx       <= '0;
      tmo_cnt       <= '0;
      cache_we_o    <= 1'b0;
      cache_adr_o   <= '0;
      cache_wdata_o <= '0;
      resp_valid_o  <= '0;
      resp_err_o    <= '0;
      resp_rdata_o  <= '0;
    end else begin
      resp_valid_o <= '0;
      resp_err_o   <= '0;
      case (state)
        IDLE: begin
          if (grant) begin
            gnt_idx       <= win_idx;
            cache_we_o    <= req_we_i[win_idx];
            cache_adr_o   <= req_adr_i[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
            cache_wdata_o <= req_wdata_i[win_idx*DATA_WIDTH +: DATA_WIDTH];
            tmo_cnt       <= '0;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (tmo_hit) begin
            resp_valid_o <= gnt_oh;
            resp_err_o   <= gnt_oh;
            resp_rdata_o <= '0;
            prio_ptr     <= nxt_ptr;
            state        <= IDLE;
          end else if (cache_ready_i) begin
            state <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          // A response on the final allowed cycle takes priority over the timeout.
          if (cache_resp_valid_i) begin
            resp_valid_o <= gnt_oh;
            resp_rdata_o <= cache_rdata_i;
            prio_ptr     <= nxt_ptr;
            state        <= IDLE;
          end else if (tmo_hit) begin
            resp_valid_o <= gnt_oh;
            resp_err_o   <= gnt_oh;
            resp_rdata_o <= '0;
            prio_ptr     <= nxt_ptr;
            state        <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed vector table, hand sequences for timeout/reset/contention, random vs reference model.
// Latency: inputs driven on the falling edge, outputs sampled 1ns later, state advances on the rising edge.
// Backpressure: cache_ready_i and response delay randomised; requesters hold valid until granted.
module tb_cache_arbiter;

  localparam int N   = 3;
  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [N-1:0]  req_valid_i, req_ready_o, req_we_i;
  logic [N*AW-1:0] req_adr_i;
  logic [N*DW-1:0] req_wdata_i;
  logic [N-1:0]  resp_valid_o, resp_err_o;
  logic [DW-1:0] resp_rdata_o;
  logic          cache_valid_o, cache_ready_i, cache_we_o;
  logic [AW-1:0] cache_adr_o;
  logic [DW-1:0] cache_wdata_o, cache_rdata_i;
  logic          cache_resp_valid_i, busy_o;

  always #5 clk_i = ~clk_i;

  cache_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_adr_i(req_adr_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_err_o(resp_err_o), .resp_rdata_o(resp_rdata_o),
    .cache_valid_o(cache_valid_o), .cache_ready_i(cache_ready_i), .cache_we_o(cache_we_o),
    .cache_adr_o(cache_adr_o), .cache_wdata_o(cache_wdata_o), .cache_rdata_i(cache_rdata_i),
    .cache_resp_valid_i(cache_resp_valid_i), .busy_o(busy_o)
  );

  // Per-requester payloads, packed onto the flat buses.
  logic [AW-1:0] p_adr [N];
  logic [DW-1:0] p_wd  [N];
  logic          p_we  [N];
  logic          pend  [N];

  always_comb begin
    req_adr_i   = '0;
    req_wdata_i = '0;
    for (int k = 0; k < N; k++) begin
      req_adr_i[k*AW +: AW]   = p_adr[k];
      req_wdata_i[k*DW +: DW] = p_wd[k];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] rdy, input logic cv, input logic cwe,
                           input logic [15:0] cadr, input logic [31:0] cwd, input logic busy,
                           input logic [2:0] rvld, input logic [2:0] rerr, input logic [31:0] rdat);
    chk({tag, ".req_ready"}, req_ready_o, rdy);
    chk({tag, ".cache_valid"}, cache_valid_o, cv);
    chk({tag, ".cache_we"}, cache_we_o, cwe);
    chk({tag, ".cache_adr"}, cache_adr_o, cadr);
    chk({tag, ".cache_wdata"}, cache_wdata_o, cwd);
    chk({tag, ".busy"}, busy_o, busy);
    chk({tag, ".resp_valid"}, resp_valid_o, rvld);
    chk({tag, ".resp_err"}, resp_err_o, rerr);
    chk({tag, ".resp_rdata"}, resp_rdata_o, rdat);
  endtask

  // One cycle: drive on the falling edge, settle, then the caller samples.
  task automatic step(input logic rst, input logic [2:0] rv, input logic [2:0] we, input logic ardy,
                      input logic rspv, input logic [31:0] rdat);
    @(negedge clk_i);
    rst_i              = rst;
    req_valid_i        = rv;
    req_we_i           = we;
    cache_ready_i      = ardy;
    cache_resp_valid_i = rspv;
    cache_rdata_i      = rdat;
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic [2:0]  rv, we;
    logic        ardy, rspv;
    logic [31:0] rdat;
    logic [2:0]  e_rdy;
    logic        e_cv, e_cwe;
    logic [15:0] e_cadr;
    logic [31:0] e_cwd;
    logic        e_busy;
    logic [2:0]  e_rvld, e_rerr;
    logic [31:0] e_rdat;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic rst, input logic [2:0] rv, input logic [2:0] we, input logic ardy,
                     input logic rspv, input logic [31:0] rdat, input logic [2:0] e_rdy, input logic e_cv,
                     input logic e_cwe, input logic [15:0] e_cadr, input logic [31:0] e_cwd,
                     input logic e_busy, input logic [2:0] e_rvld, input logic [2:0] e_rerr,
                     input logic [31:0] e_rdat);
    tbl.push_back('{rst, rv, we, ardy, rspv, rdat, e_rdy, e_cv, e_cwe, e_cadr, e_cwd, e_busy,
                    e_rvld, e_rerr, e_rdat});
  endtask

  // Reference model state (transaction level).
  bit          m_busy, m_wait;
  int          m_el, m_idx, m_ptr, w;
  logic        m_we;
  logic [15:0] m_adr;
  logic [31:0] m_wd, m_rdat;
  logic [2:0]  m_rvld, m_rerr, e_rdy;
  bit          c_wait;
  int          c_dly;
  logic        r, ardy, rspv;
  logic [31:0] rdat;
  int          exp_g[4];

  initial begin
    rst_i = 1'b1; req_valid_i = '0; req_we_i = '0; cache_ready_i = 1'b0;
    cache_resp_valid_i = 1'b0; cache_rdata_i = '0;
    for (int k = 0; k < N; k++) begin
      p_adr[k] = 16'(16'h0010 * (k + 1));
      p_wd[k]  = 32'hA0A0_0000 + 32'(k);
      p_we[k]  = 1'b0;
      pend[k]  = 1'b0;
    end
    repeat (2) @(negedge clk_i);

    // ---- directed table: single read, stale response, backpressure ----
    row(1, 3'b000, 3'b000, 0, 0, 0,            3'b000, 0, 0, 16'h0000, 32'h0,         0, 3'b000, 3'b000, 32'h0);
    row(0, 3'b001, 3'b000, 1, 0, 0,            3'b001, 0, 0, 16'h0000, 32'h0,         0, 3'b000, 3'b000, 32'h0);
    row(0, 3'b000, 3'b000, 1, 0, 0,            3'b000, 1, 0, 16'h0010, 32'hA0A00000, 1, 3'b000, 3'b000, 32'h0);
    row(0, 3'b000, 3'b000, 0, 0, 0,            3'b000, 0, 0, 16'h0010, 32'hA0A00000, 1, 3'b000, 3'b000, 32'h0);
    row(0, 3'b000, 3'b000, 0, 0, 0,            3'b000, 0, 0, 16'h0010, 32'hA0A00000, 1, 3'b000, 3'b000, 32'h0);
    row(0, 3'b000, 3'b000, 0, 1, 32'hDEADBEEF, 3'b000, 0, 0, 16'h0010, 32'hA0A00000, 1, 3'b000, 3'b000, 32'h0);
    row(0, 3'b000, 3'b000, 0, 0, 0,            3'b000, 0, 0, 16'h0010, 32'hA0A00000, 0, 3'b001, 3'b000, 32'hDEADBEEF);
    row(0, 3'b000, 3'b000, 0, 0, 0,            3'b000, 0, 0, 16'h0010, 32'hA0A00000, 0, 3'b000, 3'b000, 32'hDEADBEEF);
    row(0, 3'b010, 3'b000, 0, 1, 32'h11111111, 3'b010, 0, 0, 16'h0010, 32'hA0A00000, 0, 3'b000, 3'b000, 32'hDEADBEEF);
    row(0, 3'b000, 3'b000, 0, 1, 32'h11111111, 3'b000, 1, 0, 16'h0020, 32'hA0A00001, 1, 3'b000, 3'b000, 32'hDEADBEEF);
    row(0, 3'b000, 3'b000, 1, 1, 32'h22222222, 3'b000, 1, 0, 16'h0020, 32'hA0A00001, 1, 3'b000, 3'b000, 32'hDEADBEEF);
    row(0, 3'b000, 3'b000, 0, 1, 32'h33333333, 3'b000, 0, 0, 16'h0020, 32'hA0A00001, 1, 3'b000, 3'b000, 32'hDEADBEEF);
    row(0, 3'b000, 3'b000, 0, 0, 0,            3'b000, 0, 0, 16'h0020, 32'hA0A00001, 0, 3'b010, 3'b000, 32'h33333333);
    row(0, 3'b100, 3'b100, 0, 0, 0,            3'b100, 0, 0, 16'h0020, 32'hA0A00001, 0, 3'b000, 3'b000, 32'h33333333);
    for (int c = 0; c < 5; c++)
      row(0, 3'b110, 3'b100, 0, 0, 0,          3'b000, 1, 1, 16'h0030, 32'hA0A00002, 1, 3'b000, 3'b000, 32'h33333333);
    row(0, 3'b110, 3'b100, 1, 0, 0,            3'b000, 1, 1, 16'h0030, 32'hA0A00002, 1, 3'b000, 3'b000, 32'h33333333);
    row(0, 3'b000, 3'b000, 0, 1, 32'h44444444, 3'b000, 0, 1, 16'h0030, 32'hA0A00002, 1, 3'b000, 3'b000, 32'h33333333);
    row(0, 3'b000, 3'b000, 0, 0, 0,            3'b000, 0, 1, 16'h0030, 32'hA0A00002, 0, 3'b100, 3'b000, 32'h44444444);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].rv, tbl[i].we, tbl[i].ardy, tbl[i].rspv, tbl[i].rdat);
      check_all($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_cv, tbl[i].e_cwe, tbl[i].e_cadr,
                tbl[i].e_cwd, tbl[i].e_busy, tbl[i].e_rvld, tbl[i].e_rerr, tbl[i].e_rdat);
    end

    // ---- timeout: 8 cycles in ISSUE+WAIT_RESP, then a normal request ----
    step(0, 3'b001, 3'b000, 0, 0, 0);
    chk("to.grant", req_ready_o, 3'b001);
    for (int c = 1; c <= TMO; c++) begin
      step(0, 3'b000, 3'b000, c >= 4, 0, 0);
      chk($sformatf("to.busy%0d", c), busy_o, 1'b1);
      chk($sformatf("to.cvld%0d", c), cache_valid_o, c <= 4);
      chk($sformatf("to.rvld%0d", c), resp_valid_o, 3'b000);
    end
    step(0, 3'b001, 3'b000, 0, 0, 0);
    chk("to.pulse_vld", resp_valid_o, 3'b001);
    chk("to.pulse_err", resp_err_o, 3'b001);
    chk("to.pulse_rdata", resp_rdata_o, 32'h0);
    chk("to.busy_after", busy_o, 1'b0);
    chk("to.next_grant", req_ready_o, 3'b001);
    step(0, 3'b000, 3'b000, 1, 0, 0);
    chk("to.next_cvld", cache_valid_o, 1'b1);
    step(0, 3'b000, 3'b000, 0, 1, 32'h55AA55AA);
    chk("to.next_wait", resp_valid_o, 3'b000);
    step(0, 3'b000, 3'b000, 0, 0, 0);
    chk("to.next_vld", resp_valid_o, 3'b001);
    chk("to.next_err", resp_err_o, 3'b000);
    chk("to.next_rdata", resp_rdata_o, 32'h55AA55AA);

    // ---- reset in WAIT_RESP, coinciding with a response ----
    step(0, 3'b010, 3'b010, 0, 0, 0);
    chk("rst.grant", req_ready_o, 3'b010);
    step(0, 3'b000, 3'b000, 1, 0, 0);
    step(0, 3'b000, 3'b000, 0, 0, 0);
    chk("rst.in_wait", busy_o, 1'b1);
    step(1, 3'b000, 3'b000, 0, 1, 32'h99999999);
    step(0, 3'b000, 3'b000, 0, 0, 0);
    check_all("rst.after", 3'b000, 0, 0, 16'h0, 32'h0, 0, 3'b000, 3'b000, 32'h0);
    step(0, 3'b000, 3'b000, 0, 0, 0);
    chk("rst.no_pulse", resp_valid_o, 3'b000);

    // ---- contention: 0 and 1 held, grants alternate, grant shares cycle with previous pulse ----
    exp_g = '{0, 1, 0, 1};
    for (int t = 0; t < 4; t++) begin
      step(0, 3'b011, 3'b000, 0, 0, 0);
      chk($sformatf("rr.grant%0d", t), req_ready_o, 3'(1 << exp_g[t]));
      if (t > 0) begin
        chk($sformatf("rr.resp%0d", t - 1), resp_valid_o, 3'(1 << exp_g[t-1]));
        chk($sformatf("rr.rdata%0d", t - 1), resp_rdata_o, 32'hC0DE0000 + 32'(t - 1));
      end
      step(0, 3'b011, 3'b000, 1, 0, 0);
      chk($sformatf("rr.adr%0d", t), cache_adr_o, 16'(16'h0010 * (exp_g[t] + 1)));
      step(0, 3'b011, 3'b000, 0, 1, 32'hC0DE0000 + 32'(t));
      chk($sformatf("rr.busy_rdy%0d", t), req_ready_o, 3'b000);
    end
    step(0, 3'b000, 3'b000, 0, 0, 0);
    chk("rr.resp3", resp_valid_o, 3'(1 << exp_g[3]));
    chk("rr.rdata3", resp_rdata_o, 32'hC0DE0003);

    // ---- random traffic against the reference model ----
    step(1, 3'b000, 3'b000, 0, 0, 0);
    step(1, 3'b000, 3'b000, 0, 0, 0);
    m_busy = 0; m_wait = 0; m_el = 0; m_idx = 0; m_ptr = 0; m_we = 0; m_adr = '0; m_wd = '0;
    m_rvld = '0; m_rerr = '0; m_rdat = '0; c_wait = 0; c_dly = 0;
    for (int k = 0; k < N; k++) pend[k] = 1'b0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk_i);
      r = ($urandom_range(0, 249) == 0);
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(0, 2) == 0) begin
          pend[k]  = 1'b1;
          p_we[k]  = 1'($urandom);
          p_adr[k] = 16'($urandom);
          p_wd[k]  = $urandom;
        end
        req_valid_i[k] = pend[k];
        req_we_i[k]    = p_we[k];
      end
      ardy = 1'($urandom_range(0, 1));
      rspv = (c_wait && c_dly == 0) || ($urandom_range(0, 7) == 0);
      rdat = $urandom;
      rst_i = r; cache_ready_i = ardy; cache_resp_valid_i = rspv; cache_rdata_i = rdat;
      #1;

      e_rdy = '0;
      w = -1;
      if (!m_busy && !r) begin
        for (int j = 0; j < N; j++) begin
          if (w < 0 && req_valid_i[(m_ptr + j) % N]) w = (m_ptr + j) % N;
        end
        if (w >= 0) e_rdy = 3'(1 << w);
      end
      check_all("rnd", e_rdy, m_busy && !m_wait, m_we, m_adr, m_wd, m_busy, m_rvld, m_rerr, m_rdat);

      if (r) begin
        m_busy = 0; m_wait = 0; m_el = 0; m_ptr = 0; m_we = 0; m_adr = '0; m_wd = '0;
        m_rvld = '0; m_rerr = '0; m_rdat = '0;
      end else begin
        m_rvld = '0; m_rerr = '0;
        if (!m_busy) begin
          if (w >= 0) begin
            m_busy = 1; m_wait = 0; m_el = 0; m_idx = w;
            m_we = p_we[w]; m_adr = p_adr[w]; m_wd = p_wd[w];
          end
        end else if (m_wait && rspv) begin
          m_rvld = 3'(1 << m_idx); m_rdat = rdat; m_busy = 0; m_ptr = (m_idx + 1) % N;
        end else if (m_el + 1 == TMO) begin
          m_rvld = 3'(1 << m_idx); m_rerr = 3'(1 << m_idx); m_rdat = '0;
          m_busy = 0; m_ptr = (m_idx + 1) % N;
        end else begin
          if (!m_wait && ardy) m_wait = 1;
          m_el++;
        end
      end

      for (int k = 0; k < N; k++) if (req_ready_o[k]) pend[k] = 1'b0;
      if (r) begin
        c_wait = 0;
      end else begin
        if (c_wait && c_dly == 0) c_wait = 0;
        else if (c_wait) c_dly--;
        if (cache_valid_o && ardy) begin
          c_wait = 1;
          c_dly  = $urandom_range(0, 11);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter NUM_REQ, 2, number of requesters sharing the cache CPU port (2..8).
REQ-002 Parameter ADDR_WIDTH, 16, address width.
REQ-003 Parameter DATA_WIDTH, 32, data width.
REQ-004 Parameter TIMEOUT_CYCLES, 64, max cycles in ISSUE+WAIT_RESP before error; 0 disables timeout.
REQ-005 Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  NUM_REQ  per-requester request valid
- req_ready_o  out  NUM_REQ  one-hot pulse: request captured
- req_we_i  in  NUM_REQ  per-requester write enable
- req_adr_i  in  NUM_REQ*ADDR_WIDTH  requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata_i  in  NUM_REQ*DATA_WIDTH  requester k at [k*DATA_WIDTH +: DATA_WIDTH]
- resp_valid_o  out  NUM_REQ  one-hot one-cycle response pulse
- resp_err_o  out  NUM_REQ  one-hot timeout flag, coincident with resp_valid_o
- resp_rdata_o  out  DATA_WIDTH  response data, shared by all requesters
- cache_valid_o  out  1  request to cache
- cache_ready_i  in  1  cache accepts request
- cache_we_o  out  1  write enable to cache
- cache_adr_o  out  ADDR_WIDTH  address to cache
- cache_wdata_o  out  DATA_WIDTH  write data to cache
- cache_rdata_i  in  DATA_WIDTH  cache read data
- cache_resp_valid_i  in  1  cache response valid
- busy_o  out  1  high whenever state != IDLE

Function
REQ-006 FSM states: IDLE, ISSUE, WAIT_RESP; at most one outstanding transaction.
REQ-007 IDLE: if any req_valid_i, select winner by round-robin starting at prio_ptr; latch index, we, adr, wdata; assert req_ready_o[winner] combinationally that cycle only; next state ISSUE.
REQ-008 req_ready_o SHALL be all-zero outside IDLE and when no req_valid_i is set.
REQ-009 ISSUE: cache_valid_o=1; cache_we_o/adr_o/wdata_o driven from latched registers, stable until accepted; on cache_ready_i=1 go to WAIT_RESP.
REQ-010 cache_valid_o SHALL be 0 in IDLE and WAIT_RESP; cache_we_o/adr_o/wdata_o hold last latched value.
REQ-011 WAIT_RESP: on cache_resp_valid_i=1, register resp_valid_o[gnt]=1 and resp_rdata_o=cache_rdata_i for exactly one cycle; prio_ptr <= (gnt+1) mod NUM_REQ; go to IDLE.
REQ-012 cache_resp_valid_i SHALL be ignored in IDLE and ISSUE (stale/held responses discarded).
REQ-013 resp_rdata_o holds its last value when resp_valid_o is all-zero.
REQ-014 Timeout counter: cleared on entry to ISSUE, increments each cycle in ISSUE/WAIT_RESP; when it reaches TIMEOUT_CYCLES without a response, pulse resp_valid_o[gnt] and resp_err_o[gnt], resp_rdata_o=0, advance prio_ptr, return to IDLE. Response arriving on the timeout cycle wins (no error).
REQ-015 Timeout in ISSUE drops cache_valid_o the following cycle without acceptance.
REQ-016 Minimum latency: req accepted cycle 0, cache_valid_o cycle 1; response pulse one cycle after cache_resp_valid_i sampled; new grant allowed in the same cycle as the response pulse.
REQ-017 Requester inputs after acceptance do not affect the in-flight transaction; a requester keeping req_valid_i high re-enters arbitration.

Reset
REQ-018 rst_i=1 at a clock edge: state=IDLE, prio_ptr=0, timeout counter=0, latched regs=0, all outputs 0; takes precedence over any event, including mid-transaction (transaction abandoned, no response pulse).

Verification
REQ-019 Single: req_valid_i=01, adr0=0x0010, we=0; cache_ready_i=1, resp after 3 cycles rdata=0xDEADBEEF -> req_ready_o=01 cycle 0, cache_valid_o cycle 1, resp_valid_o=01 with 0xDEADBEEF.
REQ-020 Contention: req_valid_i=11 held continuously, 4 transactions -> grant order 0,1,0,1; each response routed to matching bit only.
REQ-021 Backpressure: cache_ready_i=0 for 5 cycles -> cache_valid_o/adr/we/wdata stable for all 6 ISSUE cycles; req_ready_o=00 meanwhile.
REQ-022 Timeout: TIMEOUT_CYCLES=8, no cache_resp_valid_i -> resp_valid_o=resp_err_o=bit of grant, resp_rdata_o=0, exactly 8 cycles after ISSUE entry; next request serviced normally.
REQ-023 Stale response: cache_resp_valid_i=1 held in IDLE/ISSUE -> no resp_valid_o until WAIT_RESP.
REQ-024 Reset mid-WAIT_RESP -> next cycle busy_o=0, all outputs 0, no resp_valid_o; next grant to requester 0 first.
